// File: rtl/change_dispenser.sv
// Coin change dispenser: greedy refund from a four-denomination float, one coin
// per hopper handshake, with a per-coin acknowledge timeout.
module change_dispenser #(
    parameter logic [3:0] INIT_COUNT  = 4'd10,
    parameter int         ACK_TIMEOUT = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic [15:0] amount,
    input  logic        coin_in_valid,
    input  logic [1:0]  coin_in_type,
    output logic        coin_out_valid,
    output logic [1:0]  coin_out_type,
    input  logic        coin_out_ack,
    output logic        busy,
    output logic        done,
    output logic [1:0]  error_code,
    output logic [15:0] remaining,
    output logic [3:0]  count_500,
    output logic [3:0]  count_1000,
    output logic [3:0]  count_2000,
    output logic [3:0]  count_5000
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SELECT  = 2'd1;
    localparam logic [1:0] PRESENT = 2'd2;
    localparam logic [1:0] FINISH  = 2'd3;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_CHANGE  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam int             TW       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0]  TMO_LAST = TW'(ACK_TIMEOUT - 1);

    function automatic logic [15:0] coin_value(input logic [1:0] t);
        case (t)
            2'd0:    coin_value = 16'd5;
            2'd1:    coin_value = 16'd10;
            2'd2:    coin_value = 16'd20;
            default: coin_value = 16'd50;
        endcase
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        sat_inc = (c == 4'd15) ? c : c + 4'd1;
    endfunction

    logic [1:0]    state;
    logic [TW-1:0] tmo_cnt;
    logic [3:0]    cnt [4];
    logic          pick_ok;
    logic [1:0]    pick_type;
    logic          ack_take;
    logic [15:0]   rem_next;
    logic [3:0]    dep;
    logic [3:0]    take;

    assign busy           = (state != IDLE);
    assign done           = (state == FINISH);
    assign coin_out_valid = (state == PRESENT);
    assign ack_take       = (state == PRESENT) && coin_out_ack;
    assign rem_next       = remaining - coin_value(coin_out_type);

    assign count_500  = cnt[0];
    assign count_1000 = cnt[1];
    assign count_2000 = cnt[2];
    assign count_5000 = cnt[3];

    // Greedy pick: largest coin that fits the remainder and is in stock.
    always_comb begin
        pick_ok   = 1'b1;
        pick_type = 2'd0;
        if (cnt[3] != 4'd0 && remaining >= 16'd50)
            pick_type = 2'd3;
        else if (cnt[2] != 4'd0 && remaining >= 16'd20)
            pick_type = 2'd2;
        else if (cnt[1] != 4'd0 && remaining >= 16'd10)
            pick_type = 2'd1;
        else if (cnt[0] != 4'd0 && remaining >= 16'd5)
            pick_type = 2'd0;
        else
            pick_ok = 1'b0;
    end

    always_comb begin
        dep  = 4'd0;
        take = 4'd0;
        for (int i = 0; i < 4; i++) begin
            dep[i]  = coin_in_valid && (coin_in_type == 2'(i));
            take[i] = ack_take && (coin_out_type == 2'(i));
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= IDLE;
            coin_out_type <= 2'd0;
            error_code    <= ERR_OK;
            remaining     <= 16'd0;
            tmo_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining  <= amount;
                        error_code <= ERR_OK;
                        if ((amount % 16'd5) != 16'd0) begin
                            error_code <= ERR_CHANGE;
                            state      <= FINISH;
                        end else if (amount == 16'd0) begin
                            state <= FINISH;
                        end else begin
                            state <= SELECT;
                        end
                    end
                end
                SELECT: begin
                    tmo_cnt <= '0;
                    if (pick_ok) begin
                        coin_out_type <= pick_type;
                        state         <= PRESENT;
                    end else begin
                        error_code <= ERR_CHANGE;
                        state      <= FINISH;
                    end
                end
                PRESENT: begin
                    if (coin_out_ack) begin
                        remaining <= rem_next;
                        state     <= (rem_next == 16'd0) ? FINISH : SELECT;
                    end else if (tmo_cnt == TMO_LAST) begin
                        error_code <= ERR_TIMEOUT;
                        state      <= FINISH;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A deposit and a dispense of the same type in one cycle cancel out.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 4; i++)
                cnt[i] <= INIT_COUNT;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (dep[i] && !take[i])
                    cnt[i] <= sat_inc(cnt[i]);
                else if (take[i] && !dep[i])
                    cnt[i] <= cnt[i] - 4'd1;
            end
        end
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter INIT_COUNT, default 4'd10, SHALL set the per-denomination coin stock loaded at reset.
REQ-002 Parameter ACK_TIMEOUT, default 8, SHALL set the number of cycles a presented coin waits for acknowledge before abort.
REQ-003 CLK  in  1  clock; all state SHALL update on its rising edge.
REQ-004 RESET  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  pulse; requests a refund of `amount`.
REQ-006 amount  in  16  refund value in units of 100 (500=5, 1000=10, 2000=20, 5000=50).
REQ-007 coin_in_valid  in  1  one accepted coin deposited into the float this cycle.
REQ-008 coin_in_type  in  2  deposited coin type: 00=500, 01=1000, 10=2000, 11=5000.
REQ-009 coin_out_valid  out  1  a coin is presented to the hopper.
REQ-010 coin_out_type  out  2  presented coin type, same encoding as coin_in_type.
REQ-011 coin_out_ack  in  1  hopper has taken the presented coin.
REQ-012 busy  out  1  a refund is in progress.
REQ-013 done  out  1  one-cycle pulse at the end of a refund.
REQ-014 error_code  out  2  00=ok, 01=cannot make change, 10=hopper ack timeout.
REQ-015 remaining  out  16  value not yet dispensed.
REQ-016 count_500, count_1000, count_2000, count_5000  out  4 each  current float stock.

Function
REQ-017 The FSM SHALL have states IDLE, SELECT, PRESENT and FINISH; busy SHALL be 1 in SELECT, PRESENT and FINISH.
REQ-018 In IDLE, start SHALL load remaining with amount and clear error_code.
- If amount%5!=0: error_code SHALL be 01 and the next state SHALL be FINISH.
- Else if amount==0: the next state SHALL be FINISH.
- Else: the next state SHALL be SELECT.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 SELECT SHALL last one cycle and pick, greedily, the largest denomination with value<=remaining and count>0.
- The next state SHALL be PRESENT with coin_out_type registered.
- If no denomination qualifies: error_code SHALL be 01 and the next state SHALL be FINISH.
REQ-021 In PRESENT, coin_out_valid SHALL be 1 and coin_out_type SHALL stay stable until ack.
REQ-022 On coin_out_ack in PRESENT:
- The selected count SHALL decrement by 1 and remaining SHALL drop by the coin value.
- The next state SHALL be FINISH if the new remaining is 0, else SELECT.
REQ-023 coin_out_ack outside PRESENT SHALL be ignored.
REQ-024 If ACK_TIMEOUT consecutive PRESENT cycles pass without ack:
- error_code SHALL be 10 and the next state SHALL be FINISH.
- count and remaining SHALL be unchanged.
REQ-025 FINISH SHALL last one cycle with done=1, then return to IDLE unconditionally.
REQ-026 error_code and remaining SHALL hold after FINISH until the next accepted start.
REQ-027 Coins dispensed before a failure SHALL stay dispensed; remaining SHALL report the undispensed value.
REQ-028 Latency: start sampled at edge N gives SELECT at N+1 and coin_out_valid at N+2; with ack held high, each coin SHALL take 2 cycles.
REQ-029 coin_in_valid SHALL increment the matching count in any state, saturating at 15; excess deposits SHALL be dropped silently.
REQ-030 If a deposit and an ack-decrement of the same type occur in the same cycle, that count SHALL be unchanged.
REQ-031 A deposit SHALL be visible to the next SELECT.
REQ-032 Subtraction SHALL be 16-bit unsigned and SHALL never underflow, since selection guarantees value<=remaining.

Reset
REQ-033 RESET SHALL force IDLE at any time, including mid-PRESENT.
REQ-034 RESET SHALL clear busy, done, coin_out_valid, coin_out_type, error_code, remaining and the timeout counter to 0.
REQ-035 RESET SHALL load every count with INIT_COUNT.
REQ-036 No coin SHALL be counted as dispensed across a reset.

Verification
REQ-037 Defaults, ack tied high, start amount=85 -> coin types 11,10,01,00 in order; counts 9,9,9,9; remaining 0; done pulse; error_code 00.
REQ-038 start amount=7 -> no coin_out_valid; done 2 cycles after start; error_code 01; remaining 7.
REQ-039 INIT_COUNT=1, start amount=45 -> coins 10,01,00; then error_code 01 with remaining 10; counts 500=0, 1000=0, 2000=0, 5000=1.
REQ-040 ack held low, start amount=50 -> coin_out_valid high for 8 cycles; then error_code 10; count_5000 stays 10; remaining 50.
REQ-041 coin_in_type=01 valid for 6 cycles -> count_1000 saturates at 15; deposit of 11 with an ack of 11 in the same cycle -> count_5000 unchanged.
REQ-042 RESET asserted during PRESENT -> outputs immediately 0; counts at INIT_COUNT; a following start amount=5 completes normally.
